// File: rtl/icache_resp_unit.sv
// Blocking direct-mapped instruction cache responder, one word per line.
// Serves fetch requests, fills misses over a single-outstanding read port.
module icache_resp_unit #(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic [31:0] resp_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    input  logic        flush_i,
    input  logic        inv_valid,
    output logic        inv_ready,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_ack,
    input  logic        mem_ret_valid,
    input  logic [31:0] mem_ret_data
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic               drop_q, drop_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill_en;

    assign idx = addr_q[IDX_W+1:2];
    assign tag = addr_q[31:IDX_W+2];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    assign resp_data = resp_data_q;

    // Next-state, handshakes and fill control
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        drop_d      = drop_q;
        resp_data_d = resp_data_q;
        valid_d     = valid_q;
        fill_en     = 1'b0;
        req_ready   = 1'b0;
        inv_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_rd_req  = 1'b0;
        mem_rd_addr = '0;
        unique case (state_q)
            IDLE: begin
                if (rst_n && !flush_i && inv_valid) begin
                    valid_d   = '0;
                    inv_ready = 1'b1;
                end else if (rst_n && !flush_i) begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        addr_d  = req_addr;
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (hit) begin
                    resp_data_d = data_q[idx];
                    state_d     = RESP;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_rd_req = 1'b1;
                // byte offset bits are always presented as zero
                mem_rd_addr = {addr_q[31:2], addr_q[1:0] & 2'b00};
                if (flush_i) drop_d = 1'b1;
                if (mem_rd_ack) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_ret_valid) begin
                    fill_en      = 1'b1;
                    valid_d[idx] = 1'b1;
                    if (drop_q || flush_i) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        resp_data_d = mem_ret_data;
                        state_d     = RESP;
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (resp_ready) begin
                    req_ready = !inv_valid;
                    if (req_valid && !inv_valid) begin
                        addr_d  = req_addr;
                        state_d = LOOKUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and line valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            drop_q      <= 1'b0;
            resp_data_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            drop_q      <= drop_d;
            resp_data_q <= resp_data_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data arrays, written on fill only
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_ret_data;
        end
    end

endmodule

// File: tb/tb_icache_resp_unit.sv
// Directed bench for icache_resp_unit.
// Inputs driven and outputs sampled around the falling clock edge.
module tb_icache_resp_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] resp_data;
    logic        resp_valid;
    logic        resp_ready;
    logic        flush_i;
    logic        inv_valid;
    logic        inv_ready;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic        mem_ret_valid;
    logic [31:0] mem_ret_data;

    int checks = 0;
    int errors = 0;

    icache_resp_unit #(.LINES(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .resp_data(resp_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .flush_i(flush_i),
        .inv_valid(inv_valid),
        .inv_ready(inv_ready),
        .mem_rd_req(mem_rd_req),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack(mem_rd_ack),
        .mem_ret_valid(mem_ret_valid),
        .mem_ret_data(mem_ret_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, exp);
        end
    endtask

    // Present a request at a negedge; leaves us one cycle later (LOOKUP)
    task automatic accept(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        #1 chk("req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("lookup_no_memreq", 32'(mem_rd_req), 32'd0);
    endtask

    // From LOOKUP: expect a miss, ack after dly cycles, return data
    task automatic serve_miss(input logic [31:0] a, input logic [31:0] d,
                              input int dly);
        @(negedge clk);
        for (int i = 0; i <= dly; i++) begin
            #1 chk("mem_rd_req", 32'(mem_rd_req), 32'd1);
            chk("mem_rd_addr", mem_rd_addr, a);
            mem_rd_ack = (i == dly);
            @(negedge clk);
        end
        mem_rd_ack = 1'b0;
        #1 chk("one_outstanding", 32'(mem_rd_req), 32'd0);
        mem_ret_valid = 1'b1;
        mem_ret_data  = d;
        @(negedge clk);
        mem_ret_valid = 1'b0;
        mem_ret_data  = '0;
    endtask

    // In RESP: check word, consume it, check valid drops
    task automatic take_resp(input logic [31:0] d);
        #1 chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_data", resp_data, d);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1 chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    endtask

    // Hit path: from LOOKUP, word appears next cycle (T+2)
    task automatic hit_resp(input logic [31:0] d);
        @(negedge clk);
        #1 chk("hit_no_memreq", 32'(mem_rd_req), 32'd0);
        take_resp(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b1;
        req_addr      = 32'h1c000000;
        resp_ready    = 1'b0;
        flush_i       = 1'b0;
        inv_valid     = 1'b0;
        mem_rd_ack    = 1'b0;
        mem_ret_valid = 1'b0;
        mem_ret_data  = '0;
        @(negedge clk);
        #1 chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
        chk("rst_mem_rd_addr", mem_rd_addr, 32'd0);
        chk("rst_inv_ready", 32'(inv_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);

        // cold miss, ack held off two cycles
        accept(32'h1c000000);
        serve_miss(32'h1c000000, 32'h02803c0c, 2);
        take_resp(32'h02803c0c);

        // repeat hit with 5-cycle stall and a pending request
        accept(32'h1c000003);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h1c000000;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_data", resp_data, 32'h02803c0c);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_memreq", 32'(mem_rd_req), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1 chk("b2b_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        #1 chk("b2b_gap", 32'(resp_valid), 32'd0);
        hit_resp(32'h02803c0c);

        // flush one cycle after ack: fill happens, no response
        accept(32'h1c000040);
        @(negedge clk);
        #1 chk("fl_memreq", 32'(mem_rd_req), 32'd1);
        chk("fl_memaddr", mem_rd_addr, 32'h1c000040);
        mem_rd_ack = 1'b1;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        flush_i    = 1'b1;
        #1 chk("fl_req_block", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush_i       = 1'b0;
        mem_ret_valid = 1'b1;
        mem_ret_data  = 32'h4c000020;
        #1 chk("fl_no_resp_ret", 32'(resp_valid), 32'd0);
        @(negedge clk);
        mem_ret_valid = 1'b0;
        #1 chk("fl_no_resp", 32'(resp_valid), 32'd0);
        chk("fl_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        #1 chk("fl_no_resp2", 32'(resp_valid), 32'd0);
        accept(32'h1c000040);
        hit_resp(32'h4c000020);

        // flush in RESP with resp_ready high: word discarded
        accept(32'h1c000040);
        @(negedge clk);
        flush_i    = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        #1 chk("flr_valid", 32'(resp_valid), 32'd1);
        chk("flr_req_block", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush_i    = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        #1 chk("flr_dropped", 32'(resp_valid), 32'd0);

        // conflict on index 0
        accept(32'h1c000100);
        serve_miss(32'h1c000100, 32'h11111111, 0);
        take_resp(32'h11111111);
        accept(32'h1c000000);
        serve_miss(32'h1c000000, 32'h02803c0c, 1);
        take_resp(32'h02803c0c);

        // invalidate: flush has priority, then inv beats req
        inv_valid = 1'b1;
        req_valid = 1'b1;
        flush_i   = 1'b1;
        #1 chk("inv_vs_flush", 32'(inv_ready), 32'd0);
        flush_i = 1'b0;
        #1 chk("inv_ready", 32'(inv_ready), 32'd1);
        chk("inv_blocks_req", 32'(req_ready), 32'd0);
        @(negedge clk);
        inv_valid = 1'b0;
        req_valid = 1'b0;
        #1 chk("inv_one_cycle", 32'(inv_ready), 32'd0);
        accept(32'h1c000000);
        serve_miss(32'h1c000000, 32'h02803c0c, 0);
        take_resp(32'h02803c0c);
        accept(32'h1c000040);
        serve_miss(32'h1c000040, 32'h4c000020, 0);
        take_resp(32'h4c000020);

        // stray return in IDLE is ignored
        mem_ret_valid = 1'b1;
        mem_ret_data  = 32'hdeadbeef;
        @(negedge clk);
        mem_ret_valid = 1'b0;
        #1 chk("stray_no_resp", 32'(resp_valid), 32'd0);
        chk("stray_idle", 32'(req_ready), 32'd1);
        accept(32'h1c000000);
        hit_resp(32'h02803c0c);

        // reset while waiting for memory data
        accept(32'h1c000080);
        @(negedge clk);
        mem_rd_ack = 1'b1;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        inv_valid  = 1'b1;
        #1 chk("mr_resp_valid", 32'(resp_valid), 32'd0);
        chk("mr_resp_data", resp_data, 32'd0);
        chk("mr_mem_rd_req", 32'(mem_rd_req), 32'd0);
        chk("mr_mem_rd_addr", mem_rd_addr, 32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd0);
        chk("mr_inv_ready", 32'(inv_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        inv_valid = 1'b0;
        @(negedge clk);
        accept(32'h1c000000);
        serve_miss(32'h1c000000, 32'h02803c0c, 0);
        take_resp(32'h02803c0c);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
